// File: rtl/spi_periph_pkg.sv
// -----------------------------------------------------------------------------
// spi_periph_pkg
// Shared constants and types for the SPI write-only peripheral.
//   ADDR_*      : register addresses decoded from frame bits [14:8]
//   FRAME_BITS  : number of SCLK bits in a valid write frame
//   state_t     : frame FSM states
// -----------------------------------------------------------------------------
package spi_periph_pkg;

    localparam int FRAME_BITS = 16;

    localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
    localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/spi_peripheral_sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
// Brings one asynchronous pin into the clk domain through SYNC_STAGES flops,
// then one more flop used only to detect edges of the synchronised level.
// Ports:
//   clk      in  system clock
//   rst_n    in  async active-low reset
//   async_in in  asynchronous pin
//   sync_out out synchronised level
//   rise     out one-cycle pulse on synchronised 0->1
//   fall     out one-cycle pulse on synchronised 1->0
// -----------------------------------------------------------------------------
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign sync_out = r_sync[SYNC_STAGES-1];
    assign rise     = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign fall     = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/spi_peripheral.sv
// -----------------------------------------------------------------------------
// spi_peripheral
// SPI mode-0 write-only peripheral. 16-bit frames, MSB first:
// [15]=R/W (1=write), [14:8]=address, [7:0]=data. Valid writes land in one of
// five 8-bit control registers; everything else is silently dropped.
// Ports:
//   clk, rst_n        system clock, async active-low reset
//   sclk, copi, ncs   asynchronous SPI pins
//   en_reg_out_7_0    reg 0x00
//   en_reg_out_15_8   reg 0x01
//   en_reg_pwm_7_0    reg 0x02
//   en_reg_pwm_15_8   reg 0x03
//   pwm_duty_cycle    reg 0x04
//   wr_strobe         one-cycle pulse on each committed write
//
// state  | meaning
// IDLE   | waiting for chip select to fall
// SHIFT  | collecting bits on each synchronised sclk rise
// COMMIT | one cycle; decode frame and write if valid
// -----------------------------------------------------------------------------
module spi_peripheral
    import spi_periph_pkg::state_t;
    import spi_periph_pkg::IDLE;
    import spi_periph_pkg::SHIFT;
    import spi_periph_pkg::COMMIT;
    import spi_periph_pkg::ADDR_EN_OUT_7_0;
    import spi_periph_pkg::ADDR_EN_OUT_15_8;
    import spi_periph_pkg::ADDR_EN_PWM_7_0;
    import spi_periph_pkg::ADDR_EN_PWM_15_8;
    import spi_periph_pkg::ADDR_PWM_DUTY;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = spi_periph_pkg::FRAME_BITS,
    parameter int NUM_REGS    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe
);

    // Count must reach FRAME_BITS+1 to flag an over-length frame.
    localparam int CNT_W = $clog2(FRAME_BITS + 2);

    logic w_sclk_rise, w_copi, w_ncs_rise, w_ncs_fall;
    logic w_unused_sclk_sync, w_unused_sclk_fall;
    logic w_unused_copi_rise, w_unused_copi_fall, w_unused_ncs_sync;
    logic w_unused;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (sclk),
        .sync_out (w_unused_sclk_sync),
        .rise     (w_sclk_rise),
        .fall     (w_unused_sclk_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_copi (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (copi),
        .sync_out (w_copi),
        .rise     (w_unused_copi_rise),
        .fall     (w_unused_copi_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ncs (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (ncs),
        .sync_out (w_unused_ncs_sync),
        .rise     (w_ncs_rise),
        .fall     (w_ncs_fall)
    );

    assign w_unused = &{w_unused_sclk_sync, w_unused_sclk_fall,
                        w_unused_copi_rise, w_unused_copi_fall, w_unused_ncs_sync};

    state_t                  r_state, w_state_nxt;
    logic [CNT_W-1:0]        r_count;
    logic [FRAME_BITS-1:0]   r_shift;
    logic [7:0]              r_regs [NUM_REGS];
    logic                    w_clear, w_shift_en, w_commit, w_wr_valid;
    logic [6:0]              w_addr;
    logic [7:0]              w_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_shift_en  = 1'b0;
        w_commit    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_ncs_fall) begin
                    w_state_nxt = SHIFT;
                    w_clear     = 1'b1;
                end
            end
            SHIFT: begin
                // A chip-select glitch restarts the frame; a rising ncs wins
                // over a coincident sclk edge.
                if (w_ncs_fall) begin
                    w_clear = 1'b1;
                end else if (w_ncs_rise) begin
                    w_state_nxt = COMMIT;
                end else if (w_sclk_rise) begin
                    w_shift_en = 1'b1;
                end
            end
            COMMIT: begin
                w_commit    = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_shift <= '0;
        end else if (w_clear) begin
            r_count <= '0;
            r_shift <= '0;
        end else if (w_shift_en) begin
            r_shift <= {r_shift[FRAME_BITS-2:0], w_copi};
            if (r_count != CNT_W'(FRAME_BITS + 1)) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign w_addr     = r_shift[14:8];
    assign w_data     = r_shift[7:0];
    assign w_wr_valid = w_commit && (r_count == CNT_W'(FRAME_BITS))
                        && r_shift[FRAME_BITS-1] && (w_addr < 7'(NUM_REGS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else if (w_wr_valid) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_addr == 7'(i)) begin
                    r_regs[i] <= w_data;
                end
            end
        end
    end

    assign wr_strobe       = w_wr_valid;
    assign en_reg_out_7_0  = r_regs[ADDR_EN_OUT_7_0];
    assign en_reg_out_15_8 = r_regs[ADDR_EN_OUT_15_8];
    assign en_reg_pwm_7_0  = r_regs[ADDR_EN_PWM_7_0];
    assign en_reg_pwm_15_8 = r_regs[ADDR_EN_PWM_15_8];
    assign pwm_duty_cycle  = r_regs[ADDR_PWM_DUTY];

endmodule

// File: tb/tb_spi_peripheral.sv
// -----------------------------------------------------------------------------
// tb_spi_peripheral
// Directed bench: a table of frames with the register image expected after
// each, plus hand-written sequences for reset, idle noise and back-to-back.
// -----------------------------------------------------------------------------
module tb_spi_peripheral;

    logic       clk;
    logic       rst_n;
    logic       sclk;
    logic       copi;
    logic       ncs;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       wr_strobe;

    spi_peripheral dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sclk            (sclk),
        .copi            (copi),
        .ncs             (ncs),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .wr_strobe       (wr_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int edge_cnt    = 0;
    int strobe_cnt  = 0;
    int strobe_edge = -1;
    int t_ncs_rise  = 0;

    always @(posedge clk) edge_cnt++;

    always @(negedge clk) begin
        if (wr_strobe === 1'b1) begin
            strobe_cnt++;
            strobe_edge = edge_cnt;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [39:0] regs_now();
        return {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0,
                en_reg_out_15_8, en_reg_out_7_0};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Mode 0: copi set while sclk low, sampled on the rise. MSB first.
    task automatic send_frame(input logic [16:0] frame, input int nbits, input int half);
        @(negedge clk);
        ncs = 1'b0;
        wait_clk(half);
        for (int i = nbits - 1; i >= 0; i--) begin
            copi = frame[i];
            sclk = 1'b0;
            wait_clk(half);
            sclk = 1'b1;
            wait_clk(half);
        end
        sclk = 1'b0;
        wait_clk(half);
        ncs = 1'b1;
        t_ncs_rise = edge_cnt;
    endtask

    typedef struct {
        string       name;
        logic [16:0] frame;
        int          nbits;
        int          half;
        logic [39:0] exp_regs;   // {reg4, reg3, reg2, reg1, reg0}
        int          exp_strobes;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int s0;

        vecs[0] = '{"wr_out_7_0",  17'h080F0, 16, 5, 40'h00_00_00_00_F0, 1};
        vecs[1] = '{"wr_duty",     17'h084A5, 16, 5, 40'hA5_00_00_00_F0, 1};
        vecs[2] = '{"read_frame",  17'h000FF, 16, 5, 40'hA5_00_00_00_F0, 0};
        vecs[3] = '{"bad_addr",    17'h0857A, 16, 5, 40'hA5_00_00_00_F0, 0};
        vecs[4] = '{"short_15",    17'h04099, 15, 5, 40'hA5_00_00_00_F0, 0};
        // Last 16 bits look like a valid write; only the length disqualifies it.
        vecs[5] = '{"long_17",     17'h08166, 17, 5, 40'hA5_00_00_00_F0, 0};
        vecs[6] = '{"wr_out_15_8", 17'h08155, 16, 5, 40'hA5_00_00_55_F0, 1};
        vecs[7] = '{"fast_duty",   17'h08400, 16, 2, 40'h00_00_00_55_F0, 1};
        vecs[8] = '{"wr_duty2",    17'h084A5, 16, 5, 40'hA5_00_00_55_F0, 1};

        rst_n = 1'b0;
        sclk  = 1'b0;
        copi  = 1'b0;
        ncs   = 1'b1;
        wait_clk(3);
        check("reset_regs", 64'(regs_now()), 64'h0);
        check("reset_strobe", 64'(wr_strobe), 64'h0);
        rst_n = 1'b1;
        wait_clk(5);

        foreach (vecs[k]) begin
            s0 = strobe_cnt;
            send_frame(vecs[k].frame, vecs[k].nbits, vecs[k].half);
            wait_clk(8);
            check({vecs[k].name, "_regs"}, 64'(regs_now()), 64'(vecs[k].exp_regs));
            check({vecs[k].name, "_strobes"}, 64'(strobe_cnt - s0), 64'(vecs[k].exp_strobes));
            // Strobe lives in the cycle closed by the 4th edge after ncs rise.
            if (vecs[k].exp_strobes == 1)
                check({vecs[k].name, "_latency"}, 64'(strobe_edge - t_ncs_rise), 64'd3);
        end

        // Register visibility: old value through edge 3, new value after edge 4.
        s0 = strobe_cnt;
        send_frame(17'h08012, 16, 5);
        wait_clk(3);
        check("lat_before", 64'(en_reg_out_7_0), 64'hF0);
        wait_clk(1);
        check("lat_after", 64'(en_reg_out_7_0), 64'h12);
        wait_clk(6);

        // Idle noise: sclk and copi toggling with ncs high.
        s0 = strobe_cnt;
        for (int i = 0; i < 20; i++) begin
            copi = i[0];
            sclk = ~sclk;
            wait_clk(5);
        end
        sclk = 1'b0;
        wait_clk(6);
        check("noise_regs", 64'(regs_now()), 64'hA5_00_00_55_12);
        check("noise_strobes", 64'(strobe_cnt - s0), 64'd0);
        s0 = strobe_cnt;
        send_frame(17'h083C3, 16, 5);
        wait_clk(8);
        check("after_noise_regs", 64'(regs_now()), 64'hA5_C3_00_55_12);
        check("after_noise_strobes", 64'(strobe_cnt - s0), 64'd1);

        // Back-to-back with a 2-clock ncs-high gap, slow then fast sclk.
        for (int sp = 0; sp < 2; sp++) begin
            int half;
            half = (sp == 0) ? 5 : 2;
            s0 = strobe_cnt;
            send_frame(17'h08201, 16, half);
            wait_clk(1);
            send_frame(17'h08202, 16, half);
            wait_clk(8);
            check(sp == 0 ? "b2b_slow_reg" : "b2b_fast_reg", 64'(en_reg_pwm_7_0), 64'h02);
            check(sp == 0 ? "b2b_slow_strobes" : "b2b_fast_strobes",
                  64'(strobe_cnt - s0), 64'd2);
        end

        // Reset in the middle of a frame.
        @(negedge clk);
        ncs = 1'b0;
        wait_clk(5);
        for (int i = 0; i < 8; i++) begin
            copi = 1'b1;
            sclk = 1'b0;
            wait_clk(5);
            sclk = 1'b1;
            wait_clk(5);
        end
        rst_n = 1'b0;
        #1;
        check("midreset_regs", 64'(regs_now()), 64'h0);
        check("midreset_strobe", 64'(wr_strobe), 64'h0);
        wait_clk(3);
        sclk  = 1'b0;
        ncs   = 1'b1;
        rst_n = 1'b1;
        wait_clk(6);
        s0 = strobe_cnt;
        send_frame(17'h08077, 16, 5);
        wait_clk(8);
        check("post_reset_regs", 64'(regs_now()), 64'h00_00_00_00_77);
        check("post_reset_strobes", 64'(strobe_cnt - s0), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
